// File: rtl/gpio_in_conditioner.sv
// GPIO pad input conditioner: 2-flop sync, per-pin debounce, edge pulses.
// Ports: clk_i, rst_ni (sync, active-low), pad_i (raw pads),
//   db_limit_i (stable cycles, 0 acts as 1), edge_en_i (pulse enables),
//   io_o (debounced level), rise_o/fall_o (per-pin pulses),
//   chg_o (OR of enabled pulses).
// Build option: GPIO_COND_DEBOUNCE_EN enables the debounce counters;
//   when undefined the stable level follows the synchroniser each cycle.
module gpio_in_conditioner #(
  parameter int unsigned           WIDTH   = 8,
  parameter int unsigned           CNT_W   = 16,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [CNT_W-1:0] db_limit_i,
  input  logic [WIDTH-1:0] edge_en_i,
  output logic [WIDTH-1:0] io_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_COND_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] lim_m1;

  // Leff-1 with a zero limit treated as one.
  assign lim_m1 = (db_limit_i == '0) ? '0
                : db_limit_i - CNT_W'(1);

  always_comb begin
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != q_q[i]) begin
        // >= so a lowered limit commits at once
        if (cnt_q[i] >= lim_m1) begin
          q_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!rst_ni) cnt_q[i] <= '0;
      else         cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic [CNT_W-1:0] unused_db_limit;
  assign unused_db_limit = db_limit_i;

  always_comb begin
    q_d = s2_q;
  end
`endif

  always_comb begin
    rise_d = edge_en_i & ~q_q & q_d;
    fall_d = edge_en_i & q_q & ~q_d;
    chg_d  = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q    <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign io_o   = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o  = chg_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed pad patterns, pulses checked
// against an expected-event queue by a free-running monitor.
module tb_gpio_in_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pad;
  logic [15:0] db;
  logic [7:0]  en;
  logic [7:0]  io_o, rise_o, fall_o;
  logic        chg_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] io;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  cur = 8'h00;

  gpio_in_conditioner dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pad_i      (pad),
    .db_limit_i (db),
    .edge_en_i  (en),
    .io_o       (io_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .chg_o      (chg_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int leff(logic [15:0] lim);
`ifdef GPIO_COND_DEBOUNCE_EN
    return (lim == 16'd0) ? 1 : int'(lim);
`else
    return 1;
`endif
  endfunction

  task automatic push(logic [7:0] io, logic [7:0] r, logic [7:0] f);
    exp_t e;
    e.io   = io;
    e.rise = r;
    e.fall = f;
    e.chg  = |(r | f);
    expq.push_back(e);
  endtask

  // Drive a new pad level and check io_o flips exactly at edge 1+Leff.
  task automatic apply(string nm, logic [7:0] nv, logic [7:0] e);
    logic [7:0] r, f;
    int l;
    r = e & ~cur & nv;
    f = e & cur & ~nv;
    if ((r | f) != 8'h00) push(nv, r, f);
    l   = leff(db);
    en  = e;
    pad = nv;
    tick(1 + l);
    chk({nm, "_before"}, {24'd0, io_o}, {24'd0, cur});
    tick(1);
    chk({nm, "_after"}, {24'd0, io_o}, {24'd0, nv});
    cur = nv;
  endtask

  // Any pulse on the outputs must match the oldest expected event.
  always @(negedge clk) begin
    if ((rise_o | fall_o) != 8'h00 || chg_o) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse",
            {7'd0, chg_o, rise_o, fall_o, io_o}, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("pulse_io",   {24'd0, io_o},   {24'd0, e.io});
        chk("pulse_rise", {24'd0, rise_o}, {24'd0, e.rise});
        chk("pulse_fall", {24'd0, fall_o}, {24'd0, e.fall});
        chk("pulse_chg",  {31'd0, chg_o},  {31'd0, e.chg});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    pad   = 8'hFF;
    db    = 16'd4;
    en    = 8'hFF;
    tick(3);
    chk("rst_io",   {24'd0, io_o},   32'h00);
    chk("rst_rise", {24'd0, rise_o}, 32'h00);
    chk("rst_fall", {24'd0, fall_o}, 32'h00);
    chk("rst_chg",  {31'd0, chg_o},  32'h0);
    pad   = 8'h00;
    rst_n = 1'b1;
    tick(6);
    chk("rel_io", {24'd0, io_o}, 32'h00);

    db = 16'd4;
    apply("commit_rise3", 8'h08, 8'hFF);
    apply("commit_fall3", 8'h00, 8'hFF);

`ifdef GPIO_COND_DEBOUNCE_EN
    pad = 8'h01;
    tick(3);
    pad = 8'h00;
    tick(10);
    chk("glitch_io", {24'd0, io_o}, 32'h00);
    push(8'h01, 8'h01, 8'h00);
    push(8'h00, 8'h00, 8'h01);
    pad = 8'h01;
    tick(4);
    pad = 8'h00;
    chk("hold4_e3", {24'd0, io_o}, 32'h00);
    tick(1);
    chk("hold4_e4", {24'd0, io_o}, 32'h00);
    tick(1);
    chk("hold4_e5", {24'd0, io_o}, 32'h01);
    tick(4);
    chk("hold4_back", {24'd0, io_o}, 32'h00);
    tick(2);

    db = 16'd100;
    push(8'h04, 8'h04, 8'h00);
    pad = 8'h04;
    tick(12);
    chk("drop_pre", {24'd0, io_o}, 32'h00);
    db = 16'd2;
    tick(1);
    chk("drop_commit", {24'd0, io_o}, 32'h04);
    cur = 8'h04;
    db  = 16'd1;
    apply("drop_restore", 8'h00, 8'hFF);
`endif

    db = 16'd0;
    apply("lim0_rise", 8'h02, 8'hFF);
    db = 16'd1;
    apply("lim1_fall", 8'h00, 8'hFF);

    apply("multi_a", 8'h0F, 8'hFF);
    apply("multi_b", 8'hF0, 8'h3C);
    apply("mask_off", 8'h00, 8'h00);

`ifndef GPIO_COND_DEBOUNCE_EN
    db = 16'd1000;
    en = 8'hFF;
    push(8'h10, 8'h10, 8'h00);
    push(8'h00, 8'h00, 8'h10);
    pad = 8'h10;
    tick(1);
    pad = 8'h00;
    tick(1);
    chk("nodb_e1", {24'd0, io_o}, 32'h00);
    tick(1);
    chk("nodb_e2", {24'd0, io_o}, 32'h10);
    tick(1);
    chk("nodb_e3", {24'd0, io_o}, 32'h00);
`endif

    tick(6);
    chk("queue_empty", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
